// File: rtl/delay_calibrator.sv
`default_nettype none
// ============================================================================
// Module   : delay_calibrator
// Purpose  : Sweeps a 4-bit delay-line code from 0 upward. For each code it
//            waits for the line to settle, samples the feedback, and reduces
//            the samples to one bit. The bit at code 0 is the reference. The
//            first code whose bit differs from the reference is the
//            calibrated code. If all 16 codes give the reference bit, the
//            calibration fails.
// Config   : DLYCAL_FILTER_EN -- when defined, each code is sampled for
//            SAMPLES cycles and reduced by a strict majority vote. When
//            undefined, a single feedback sample is taken per code.
// Ports    : clk      - clock, rising edge
//            rst_n    - asynchronous active-low reset
//            start    - calibration request, sampled only while idle
//            dly_fb   - delay-line feedback, already synchronous to clk
//            delay    - code driven to the delay line
//            busy     - high whenever the block is not idle
//            done     - one-cycle pulse when a calibration finishes
//            locked   - last calibration found a transition
//            cal_code - code found by the last calibration (0 on failure)
//            err      - last calibration swept all codes without a transition
// Revision : 1.0 - initial release
// ============================================================================
module delay_calibrator #(
    parameter int SETTLE_CYCLES = 4,   // wait cycles after each code change (1..255)
    parameter int SAMPLES       = 8    // samples per code, power of two (2..128)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dly_fb,
    output logic [3:0] delay,
    output logic       busy,
    output logic       done,
    output logic       locked,
    output logic [3:0] cal_code,
    output logic       err
);

    // One shared phase timer serves both the settle wait and the sample
    // window. It is sized for the longer of the two phases.
    localparam int C_TMR_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
    localparam int C_TMR_W   = $clog2(C_TMR_MAX);

    localparam logic [C_TMR_W-1:0] C_SETTLE_LAST = C_TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]         C_LAST_CODE   = 4'd15;

`ifdef DLYCAL_FILTER_EN
    // The ones counter must be able to hold the value SAMPLES itself.
    localparam int                  C_ONES_W      = $clog2(SAMPLES) + 1;
    localparam logic [C_TMR_W-1:0]  C_SAMPLE_LAST = C_TMR_W'(SAMPLES - 1);
    localparam logic [C_ONES_W-1:0] C_HALF        = C_ONES_W'(SAMPLES / 2);
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_SAMPLE = 3'd2,
        S_EVAL   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [3:0]          r_code;       // code under test
    logic [C_TMR_W-1:0]  r_timer;      // cycle index within SETTLE / SAMPLE
    logic                r_ref;        // reduced feedback bit at code 0
    logic                r_locked;
    logic                r_err;
    logic [3:0]          r_cal_code;
    logic                r_done;

`ifdef DLYCAL_FILTER_EN
    logic [C_ONES_W-1:0] r_ones;       // feedback ones seen in the sample window
`else
    logic                r_fb_bit;     // single captured feedback sample
`endif

    logic                w_settle_last;
    logic                w_sample_last;
    logic                w_bit;        // reduced feedback bit for r_code
    logic                w_code_zero;
    logic                w_hit;        // transition found at r_code

    // ------------------------------------------------------------------
    // Phase decode shared by the next-state logic and the datapath.
    // ------------------------------------------------------------------
    always_comb begin
        w_settle_last = (r_timer == C_SETTLE_LAST);
`ifdef DLYCAL_FILTER_EN
        w_sample_last = (r_timer == C_SAMPLE_LAST);
        // Strict majority: an exact half counts as 0.
        w_bit         = (r_ones > C_HALF);
`else
        w_sample_last = 1'b1;
        w_bit         = r_fb_bit;
`endif
        w_code_zero   = (r_code == 4'd0);
        w_hit         = !w_code_zero && (w_bit != r_ref);
    end

    // ------------------------------------------------------------------
    // State register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (w_settle_last) begin
                    w_state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (w_sample_last) begin
                    w_state_nxt = S_EVAL;
                end
            end
            S_EVAL: begin
                if (w_code_zero) begin
                    w_state_nxt = S_SETTLE;
                end else if (w_hit || (r_code == C_LAST_CODE)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: code sweep, phase timer, sampling, and result registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code     <= 4'd0;
            r_timer    <= '0;
            r_ref      <= 1'b0;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
            r_cal_code <= 4'd0;
            r_done     <= 1'b0;
`ifdef DLYCAL_FILTER_EN
            r_ones     <= '0;
`else
            r_fb_bit   <= 1'b0;
`endif
        end else begin
            // done is registered from the DONE state. The pulse therefore
            // appears in the cycle after DONE, when the block is idle again.
            r_done <= (r_state == S_DONE);

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_locked <= 1'b0;
                        r_err    <= 1'b0;
                        r_code   <= 4'd0;
                        r_timer  <= '0;
                    end
                end
                S_SETTLE: begin
                    if (w_settle_last) begin
                        r_timer <= '0;
`ifdef DLYCAL_FILTER_EN
                        r_ones  <= '0;
`endif
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_SAMPLE: begin
`ifdef DLYCAL_FILTER_EN
                    r_ones <= r_ones + C_ONES_W'(dly_fb);
                    if (w_sample_last) begin
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
`else
                    r_fb_bit <= dly_fb;
`endif
                end
                S_EVAL: begin
                    if (w_code_zero) begin
                        r_ref  <= w_bit;
                        r_code <= 4'd1;
                    end else if (w_hit) begin
                        r_cal_code <= r_code;
                        r_locked   <= 1'b1;
                    end else if (r_code == C_LAST_CODE) begin
                        // Sweep exhausted. The code stays at 15 and does not wrap.
                        r_cal_code <= 4'd0;
                        r_err      <= 1'b1;
                    end else begin
                        r_code <= r_code + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. While idle, the line is held at the calibrated code, or at
    // code 0 when no lock exists.
    // ------------------------------------------------------------------
    always_comb begin
        busy     = (r_state != S_IDLE);
        done     = r_done;
        locked   = r_locked;
        err      = r_err;
        cal_code = r_cal_code;
        if (r_state != S_IDLE) begin
            delay = r_code;
        end else if (r_locked) begin
            delay = r_cal_code;
        end else begin
            delay = 4'd0;
        end
    end

endmodule
`default_nettype wire
